// File: rtl/uart_frame_pkg.sv
// Shared constants and types for the UART frame deframer.
// Optional inter-byte timeout is enabled by defining UART_FRAME_TIMEOUT_EN.
package uart_frame_pkg;

  localparam logic [7:0] SOF = 8'hAA;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    PAYLOAD,
    CHK,
    DRAIN
  } state_t;

  typedef enum logic [1:0] {
    ERR_LEN     = 2'd0,
    ERR_CHK     = 2'd1,
    ERR_TIMEOUT = 2'd2
  } err_code_t;

  // Address width for a buffer of 'depth' entries (at least one bit).
  function automatic int addr_bits(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// Payload register file: one synchronous write port, one combinational read port.
// Contents are deliberately not reset; the deframer only reads entries it has written.
module uart_frame_buf
  import uart_frame_pkg::*;
#(
  parameter int MAX_LEN = 16,
  parameter int AW      = addr_bits(MAX_LEN)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [MAX_LEN];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_frame_rx.sv
// Deframer for SOF/LEN/payload/XOR-checksum packets; releases payload only after CHK verifies.
// Define UART_FRAME_TIMEOUT_EN to build the inter-byte timeout (err_code 2).
module uart_frame_rx
  import uart_frame_pkg::*;
#(
  parameter int MAX_LEN     = 16,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       rx_overrun
);

  localparam int IW = $clog2(MAX_LEN + 1);
  localparam int AW = addr_bits(MAX_LEN);

  state_t    state_reg;
  err_code_t err_code_reg;
  logic [IW-1:0] len_reg;
  logic [IW-1:0] wr_idx_reg;
  logic [IW-1:0] rd_idx_reg;
  logic [7:0]    chk_reg;
  logic          out_valid_reg;
  logic          out_last_reg;
  logic          frame_ok_reg;
  logic          frame_err_reg;
  logic          rx_overrun_reg;

  logic [7:0] rd_byte;
  logic       buf_we;
  logic       transfer;
  logic       in_frame;
  logic       tmo_hit;

  assign buf_we   = (state_reg == PAYLOAD) && rx_done;
  assign transfer = out_valid_reg && out_ready;
  assign in_frame = (state_reg == LEN) || (state_reg == PAYLOAD) || (state_reg == CHK);

  uart_frame_buf #(
    .MAX_LEN (MAX_LEN),
    .AW      (AW)
  ) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (wr_idx_reg[AW-1:0]),
    .wdata (rx_data),
    .raddr (rd_idx_reg[AW-1:0]),
    .rdata (rd_byte)
  );

`ifdef UART_FRAME_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_cnt_reg;

  // Any byte clears the count, so a byte arriving on the expiry cycle wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt_reg <= '0;
    end else if (rx_done || !in_frame) begin
      tmo_cnt_reg <= '0;
    end else begin
      tmo_cnt_reg <= tmo_cnt_reg + TW'(1);
    end
  end

  assign tmo_hit = in_frame && !rx_done && (tmo_cnt_reg == TW'(TIMEOUT_CYC - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      err_code_reg   <= ERR_LEN;
      len_reg        <= '0;
      wr_idx_reg     <= '0;
      rd_idx_reg     <= '0;
      chk_reg        <= '0;
      out_valid_reg  <= 1'b0;
      out_last_reg   <= 1'b0;
      frame_ok_reg   <= 1'b0;
      frame_err_reg  <= 1'b0;
      rx_overrun_reg <= 1'b0;
    end else begin
      frame_ok_reg   <= 1'b0;
      frame_err_reg  <= 1'b0;
      rx_overrun_reg <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (rx_done && (rx_data == SOF)) begin
            state_reg <= LEN;
          end
        end

        LEN: begin
          if (rx_done) begin
            if ((rx_data == 8'd0) || (rx_data > 8'(MAX_LEN))) begin
              frame_err_reg <= 1'b1;
              err_code_reg  <= ERR_LEN;
              state_reg     <= IDLE;
            end else begin
              len_reg    <= rx_data[IW-1:0];
              chk_reg    <= rx_data;
              wr_idx_reg <= '0;
              state_reg  <= PAYLOAD;
            end
          end else if (tmo_hit) begin
            frame_err_reg <= 1'b1;
            err_code_reg  <= ERR_TIMEOUT;
            state_reg     <= IDLE;
          end
        end

        PAYLOAD: begin
          if (rx_done) begin
            chk_reg    <= chk_reg ^ rx_data;
            wr_idx_reg <= wr_idx_reg + IW'(1);
            if ((wr_idx_reg + IW'(1)) == len_reg) begin
              state_reg <= CHK;
            end
          end else if (tmo_hit) begin
            frame_err_reg <= 1'b1;
            err_code_reg  <= ERR_TIMEOUT;
            state_reg     <= IDLE;
          end
        end

        CHK: begin
          if (rx_done) begin
            if (rx_data == chk_reg) begin
              frame_ok_reg  <= 1'b1;
              out_valid_reg <= 1'b1;
              out_last_reg  <= (len_reg == IW'(1));
              rd_idx_reg    <= '0;
              state_reg     <= DRAIN;
            end else begin
              frame_err_reg <= 1'b1;
              err_code_reg  <= ERR_CHK;
              state_reg     <= IDLE;
            end
          end else if (tmo_hit) begin
            frame_err_reg <= 1'b1;
            err_code_reg  <= ERR_TIMEOUT;
            state_reg     <= IDLE;
          end
        end

        DRAIN: begin
          if (rx_done) begin
            rx_overrun_reg <= 1'b1;
          end
          if (transfer) begin
            if (out_last_reg) begin
              out_valid_reg <= 1'b0;
              out_last_reg  <= 1'b0;
              rd_idx_reg    <= '0;
              state_reg     <= IDLE;
            end else begin
              // Next index becomes the last one when rd_idx + 1 == len - 1.
              rd_idx_reg   <= rd_idx_reg + IW'(1);
              out_last_reg <= ((rd_idx_reg + IW'(2)) == len_reg);
            end
          end
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Buffer contents are unreset, so gate the byte to keep out_data at 0 outside DRAIN.
  assign out_data   = out_valid_reg ? rd_byte : 8'h00;
  assign out_valid  = out_valid_reg;
  assign out_last   = out_last_reg;
  assign frame_ok   = frame_ok_reg;
  assign frame_err  = frame_err_reg;
  assign err_code   = err_code_reg;
  assign rx_overrun = rx_overrun_reg;

endmodule

// File: tb/tb_uart_frame_rx.sv
// Self-checking bench for uart_frame_rx: table of whole frames plus hand sequences
// for backpressure/overrun, timeout (UART_FRAME_TIMEOUT_EN on or off) and async reset.
module tb_uart_frame_rx;

  localparam int MAX_LEN     = 16;
  localparam int TIMEOUT_CYC = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_done = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_last;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;
  logic       rx_overrun;

  always #5 clk = ~clk;

  uart_frame_rx #(
    .MAX_LEN     (MAX_LEN),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_done    (rx_done),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .frame_ok   (frame_ok),
    .frame_err  (frame_err),
    .err_code   (err_code),
    .rx_overrun (rx_overrun)
  );

  int tests  = 0;
  int errors = 0;

  // Event monitor: sampled on the falling edge, away from the active edge.
  int         ok_cnt  = 0;
  int         err_cnt = 0;
  int         ovr_cnt = 0;
  logic [1:0] last_code = 2'd3;
  logic [7:0] got_q[$];
  logic       got_last_q[$];

  always @(negedge clk) begin
    if (frame_ok) ok_cnt++;
    if (frame_err) begin
      err_cnt++;
      last_code = err_code;
    end
    if (rx_overrun) ovr_cnt++;
    if (out_valid && out_ready) begin
      got_q.push_back(out_data);
      got_last_q.push_back(out_last);
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1;
    rx_data = b;
    rx_done = 1'b1;
    @(posedge clk);
    #1;
    rx_done = 1'b0;
  endtask

  task automatic send_bytes(input logic [63:0] bytes, input int n);
    for (int i = 0; i < n; i++) begin
      send_byte(bytes[8*(n-1-i) +: 8]);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_stream(input string name, input int g0, input logic [63:0] exp, input int n);
    check({name, " len"}, got_q.size() - g0, n);
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s byte%0d", name, i), got_q[g0 + i], exp[8*(n-1-i) +: 8]);
      check($sformatf("%s last%0d", name, i), got_last_q[g0 + i], (i == n - 1));
    end
  endtask

  typedef struct {
    int         nbytes;
    int         nok;
    int         nerr;
    logic [1:0] code;
    int         npay;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] stim_q[$];
  logic [7:0] exp_q[$];

  task automatic push_stim(input logic [63:0] bytes, input int n);
    for (int i = 0; i < n; i++) stim_q.push_back(bytes[8*(n-1-i) +: 8]);
  endtask

  task automatic push_exp(input logic [63:0] bytes, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(bytes[8*(n-1-i) +: 8]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int sp;
    int ep;
    int ok0;
    int er0;
    int ov0;
    int g0;
    int stable_bad;
    int tmo_at;

    // Good frame, checksum error, recovery, two length errors, noise + AA-as-data, max length.
    vecs.push_back('{6, 1, 0, 2'd0, 3});
    push_stim(64'hAA_03_11_22_33_03, 6);  push_exp(64'h11_22_33, 3);
    vecs.push_back('{5, 0, 1, 2'd1, 0});
    push_stim(64'hAA_02_55_66_00, 5);
    vecs.push_back('{5, 1, 0, 2'd0, 2});
    push_stim(64'hAA_02_12_34_24, 5);     push_exp(64'h12_34, 2);
    vecs.push_back('{2, 0, 1, 2'd0, 0});
    push_stim(64'hAA_00, 2);
    vecs.push_back('{2, 0, 1, 2'd0, 0});
    push_stim(64'hAA_11, 2);
    vecs.push_back('{6, 1, 0, 2'd0, 1});
    push_stim(64'h00_55_AA_01_AA_AB, 6);  push_exp(64'hAA, 1);
    vecs.push_back('{19, 1, 0, 2'd0, 16});
    push_stim(64'hAA_10, 2);
    for (int i = 1; i <= 16; i++) begin
      stim_q.push_back(8'(i));
      exp_q.push_back(8'(i));
    end
    push_stim(64'h00, 1);

    // Reset state
    wait_cycles(3);
    check("reset out_data", out_data, 0);
    check("reset out_valid", out_valid, 0);
    check("reset flags", {out_last, frame_ok, frame_err, err_code, rx_overrun}, 0);
    rst = 1'b1;
    out_ready = 1'b1;
    wait_cycles(2);

    sp = 0;
    ep = 0;
    for (int v = 0; v < vecs.size(); v++) begin
      ok0 = ok_cnt;
      er0 = err_cnt;
      g0  = got_q.size();
      for (int i = 0; i < vecs[v].nbytes; i++) send_byte(stim_q[sp + i]);
      sp += vecs[v].nbytes;
      wait_cycles(40);
      check($sformatf("v%0d frame_ok count", v), ok_cnt - ok0, vecs[v].nok);
      check($sformatf("v%0d frame_err count", v), err_cnt - er0, vecs[v].nerr);
      if (vecs[v].nerr > 0) check($sformatf("v%0d err_code", v), last_code, vecs[v].code);
      check($sformatf("v%0d stream len", v), got_q.size() - g0, vecs[v].npay);
      for (int i = 0; i < vecs[v].npay; i++) begin
        check($sformatf("v%0d byte%0d", v, i), got_q[g0 + i], exp_q[ep + i]);
        check($sformatf("v%0d last%0d", v, i), got_last_q[g0 + i], (i == vecs[v].npay - 1));
      end
      ep += vecs[v].npay;
      check($sformatf("v%0d idle out_valid", v), out_valid, 0);
    end

    // Backpressure with an overrun byte during DRAIN
    out_ready = 1'b0;
    ok0 = ok_cnt;
    ov0 = ovr_cnt;
    g0  = got_q.size();
    send_bytes(64'hAA_03_11_22_33_03, 6);
    check("bp out_valid", out_valid, 1);
    check("bp out_data first", out_data, 8'h11);
    send_byte(8'h7E);
    stable_bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if (!out_valid || out_data !== 8'h11 || out_last) stable_bad++;
    end
    check("bp hold stable violations", stable_bad, 0);
    out_ready = 1'b1;
    wait_cycles(10);
    check("bp frame_ok count", ok_cnt - ok0, 1);
    check("bp overrun count", ovr_cnt - ov0, 1);
    check_stream("bp stream", g0, 64'h11_22_33, 3);
    check("bp out_valid after last", out_valid, 0);

    // Stalled frame: AA 04 01 then silence
    er0 = err_cnt;
    send_bytes(64'hAA_04_01, 3);
`ifdef UART_FRAME_TIMEOUT_EN
    tmo_at = -1;
    for (int c = 1; c <= 200 && tmo_at < 0; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (frame_err) tmo_at = c;
    end
    check("timeout cycles after last byte", tmo_at, TIMEOUT_CYC);
    check("timeout err_code", err_code, 2);
    wait_cycles(2);
    check("timeout frame_err count", err_cnt - er0, 1);
`else
    tmo_at = 0;
    wait_cycles(150);
    check("no-timeout frame_err count", err_cnt - er0, tmo_at);
    ok0 = ok_cnt;
    g0  = got_q.size();
    send_bytes(64'h02_03_04_00, 4);
    wait_cycles(10);
    check("stalled frame completes", ok_cnt - ok0, 1);
    check_stream("stalled stream", g0, 64'h01_02_03_04, 4);
`endif

    // Async reset mid-DRAIN: outputs drop without a clock edge
    out_ready = 1'b0;
    send_bytes(64'hAA_01_5A_5B, 4);
    check("drain before reset out_valid", out_valid, 1);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("reset mid-drain outputs", {out_data, out_valid, out_last, frame_ok, frame_err, err_code, rx_overrun}, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Async reset mid-PAYLOAD, then a fresh frame
    out_ready = 1'b1;
    ok0 = ok_cnt;
    er0 = err_cnt;
    send_bytes(64'hAA_03_11, 3);
    #3;
    rst = 1'b0;
    #1;
    check("reset mid-payload outputs", {out_data, out_valid, out_last, frame_ok, frame_err, err_code, rx_overrun}, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    g0 = got_q.size();
    send_bytes(64'hAA_01_5A_5B, 4);
    wait_cycles(10);
    check("post-reset frame_ok count", ok_cnt - ok0, 1);
    check("post-reset frame_err count", err_cnt - er0, 0);
    check_stream("post-reset stream", g0, 64'h5A, 1);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
